// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry layout for the fetch queue stage.
package fetch_pkg;

  localparam int FETCH_DATA_W = 16;
  localparam int FETCH_ADDR_W = 16;
  localparam int INSTR_BYTES  = FETCH_DATA_W / 8;

  localparam logic [FETCH_DATA_W-1:0] NOP_INSTR  = 16'h0800;
  localparam logic [FETCH_DATA_W-1:0] HALT_INSTR = 16'h0000;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_ADDR_W-1:0] next_pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Bus bundle for the fetch queue stage: control, imem handshake and decode-side queue head.
interface fetch_queue_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_next_pc;
  logic [CNT_W-1:0]  count;

  modport master (
    input  redirect, redirect_pc, halt,
    input  imem_ready, imem_rsp_valid, imem_rsp_data,
    input  out_ready,
    output imem_req, imem_addr,
    output out_valid, out_instr, out_pc, out_next_pc, count
  );

  modport slave (
    output redirect, redirect_pc, halt,
    output imem_ready, imem_rsp_valid, imem_rsp_data,
    output out_ready,
    input  imem_req, imem_addr,
    input  out_valid, out_instr, out_pc, out_next_pc, count
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer; pointers carry an extra wrap bit to tell full from empty.
module fetch_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage has no reset: validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// PC generation, single-outstanding imem request with epoch tagging, and a fetch queue to decode.
// Optional build macro FETCH_HALT_DETECT_EN: a fetched HALT opcode stops further issue until redirect.
module fetch_queue_stage #(
  parameter int                 DATA_W    = fetch_pkg::FETCH_DATA_W,
  parameter int                 ADDR_W    = fetch_pkg::FETCH_ADDR_W,
  parameter int                 DEPTH     = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_queue_stage_if.master  bus
);
  import fetch_pkg::*;

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = 2 * ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               outstanding_q, outstanding_d;
  logic               epoch_q, epoch_d;
  logic               tag_q, tag_d;
  logic               halt_seen;

  logic               issue;
  logic               accept;
  logic               rsp_hit;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [CNT_W:0]     credit_use;

  // Count plus in-flight requests must stay below DEPTH so every response has a slot.
  assign credit_use = {1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding_q};
  assign issue   = ~rst & ~bus.halt & ~bus.redirect & ~halt_seen & ~outstanding_q &
                   (credit_use < (CNT_W + 1)'(DEPTH));
  assign accept  = issue & bus.imem_ready;
  assign rsp_hit = bus.imem_rsp_valid & outstanding_q;
  assign push    = rsp_hit & (tag_q == epoch_q) & ~bus.redirect;
  assign pop     = ~fifo_empty & bus.out_ready & ~bus.redirect;

  assign push_entry = {req_addr_q, req_addr_q + STEP, bus.imem_rsp_data};

  always_comb begin
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    outstanding_d = outstanding_q;
    epoch_d       = epoch_q;
    tag_d         = tag_q;
    if (accept) begin
      pc_d          = pc_q + STEP;
      req_addr_d    = pc_q;
      outstanding_d = 1'b1;
      tag_d         = epoch_q;
    end else if (rsp_hit) begin
      outstanding_d = 1'b0;
    end
    // Redirect leaves outstanding alone: the stale response is still awaited, then dropped by tag.
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      epoch_d = ~epoch_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_addr_q    <= '0;
      outstanding_q <= 1'b0;
      epoch_q       <= 1'b0;
      tag_q         <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      outstanding_q <= outstanding_d;
      epoch_q       <= epoch_d;
      tag_q         <= tag_d;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  logic halt_seen_q, halt_seen_d;

  always_comb begin
    halt_seen_d = halt_seen_q;
    if (bus.redirect)
      halt_seen_d = 1'b0;
    else if (push && bus.imem_rsp_data == DATA_W'(HALT_INSTR))
      halt_seen_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halt_seen_q <= 1'b0;
    else     halt_seen_q <= halt_seen_d;
  end

  assign halt_seen = halt_seen_q;
`else
  assign halt_seen = 1'b0;
`endif

  fetch_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (bus.redirect),
    .push_data (push_entry),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.count       = fifo_count;
  assign bus.out_valid   = ~fifo_empty;
  assign bus.out_pc      = head_entry[ENTRY_W-1 -: ADDR_W];
  assign bus.out_next_pc = head_entry[DATA_W +: ADDR_W];
  assign bus.out_instr   = fifo_empty ? NOP_INSTR : head_entry[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage with a variable-latency imem model; memory returns addr ^ 16'hC300.
module tb_fetch_queue_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   lat_cfg = 1;
  logic halt_trap_en = 1'b0;

  always #5 clk = ~clk;

  fetch_queue_stage_if #(.DATA_W(16), .ADDR_W(16), .DEPTH(4)) bus ();

  fetch_queue_stage #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000), .NOP_INSTR(16'h0800)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (halt_trap_en && a == 16'h0006) return 16'h0000;
    return a ^ 16'hC300;
  endfunction

  // Instruction memory model: one response lat_cfg cycles after acceptance; reset with rst.
  logic        mem_busy;
  logic [15:0] mem_addr;
  int          mem_wait;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_busy           <= 1'b0;
      mem_addr           <= '0;
      mem_wait           <= 0;
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= '0;
    end else begin
      bus.imem_rsp_valid <= 1'b0;
      if (mem_busy) begin
        if (mem_wait <= 1) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= mem_fn(mem_addr);
          mem_busy           <= 1'b0;
        end else begin
          mem_wait <= mem_wait - 1;
        end
      end
      if (bus.imem_req && bus.imem_ready) begin
        if (lat_cfg <= 1) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= mem_fn(bus.imem_addr);
        end else begin
          mem_busy <= 1'b1;
          mem_addr <= bus.imem_addr;
          mem_wait <= lat_cfg - 1;
        end
      end
    end
  end

  logic [15:0]  acc_q[$];
  fetch_entry_t pop_q[$];

  always @(posedge clk) begin
    if (!rst && bus.imem_req && bus.imem_ready) begin
      acc_q.push_back(bus.imem_addr);
      $display("accept addr=%h", bus.imem_addr);
    end
    if (!rst && bus.out_valid && bus.out_ready && !bus.redirect) begin
      pop_q.push_back('{pc: bus.out_pc, next_pc: bus.out_next_pc, instr: bus.out_instr});
      $display("pop    pc=%h next_pc=%h instr=%h", bus.out_pc, bus.out_next_pc, bus.out_instr);
    end
  end

  task automatic do_reset();
    rst              = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.halt         = 1'b0;
    bus.imem_ready   = 1'b1;
    bus.out_ready    = 1'b1;
    lat_cfg          = 1;
    halt_trap_en     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    pop_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0;
    bus.imem_ready = 1'b1; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_instr !== 16'h0800) begin bad++; $display("FAIL reset_out_instr: got %h want 0800", bus.out_instr); end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    total++; if (bus.imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", bus.imem_addr); end
  endtask

  task automatic test_basic();
    do_reset();
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 16'h0800) begin bad++;
      $display("FAIL basic_nop_before_push: got valid=%b instr=%h want valid=0 instr=0800", bus.out_valid, bus.out_instr); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000 || bus.out_next_pc !== 16'h0002 || bus.out_instr !== 16'hC300) begin bad++;
      $display("FAIL basic_first_head: got v=%b pc=%h npc=%h instr=%h want v=1 pc=0000 npc=0002 instr=C300",
               bus.out_valid, bus.out_pc, bus.out_next_pc, bus.out_instr); end
    repeat (10) @(negedge clk);
    total++;
    if (acc_q.size() < 3) begin bad++; $display("FAIL basic_accepts: got %0d accepts want >=3", acc_q.size()); end
    else if (acc_q[0] !== 16'h0000 || acc_q[1] !== 16'h0002 || acc_q[2] !== 16'h0004) begin bad++;
      $display("FAIL basic_accepts: got %h %h %h want 0000 0002 0004", acc_q[0], acc_q[1], acc_q[2]); end
    total++;
    if (pop_q.size() < 3) begin bad++; $display("FAIL basic_pops: got %0d pops want >=3", pop_q.size()); end
    else if (pop_q[1].pc !== 16'h0002 || pop_q[1].next_pc !== 16'h0004 || pop_q[1].instr !== 16'hC302 ||
             pop_q[2].pc !== 16'h0004 || pop_q[2].next_pc !== 16'h0006 || pop_q[2].instr !== 16'hC304) begin bad++;
      $display("FAIL basic_pops: got pc=%h/%h npc=%h/%h want 0002/0004 0004/0006",
               pop_q[1].pc, pop_q[2].pc, pop_q[1].next_pc, pop_q[2].next_pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (20) @(negedge clk);
    total++; if (acc_q.size() != 10) begin bad++; $display("FAIL b2b_accepts: got %0d want 10", acc_q.size()); end
    total++; if (pop_q.size() != 9) begin bad++; $display("FAIL b2b_pops: got %0d want 9", pop_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL bp_count_full: got %0d want 4", bus.count); end
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_blocked: got %b want 0", bus.imem_req); end
    total++; if (acc_q.size() != 4) begin bad++; $display("FAIL bp_accepts: got %0d want 4", acc_q.size()); end
    total++; if (bus.out_pc !== 16'h0000 || bus.out_instr !== 16'hC300) begin bad++;
      $display("FAIL bp_head: got pc=%h instr=%h want 0000 C300", bus.out_pc, bus.out_instr); end
    bus.out_ready = 1'b1;
    repeat (30) @(negedge clk);
    total++;
    if (pop_q.size() < 8) begin bad++; $display("FAIL bp_drain_size: got %0d want >=8", pop_q.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        if (pop_q[i].pc !== 16'(2 * i) || pop_q[i].next_pc !== 16'(2 * i + 2) || pop_q[i].instr !== 16'hC300 + 16'(2 * i)) begin
          bad++;
          $display("FAIL bp_drain_order[%0d]: got pc=%h npc=%h instr=%h want pc=%h", i,
                   pop_q[i].pc, pop_q[i].next_pc, pop_q[i].instr, 16'(2 * i));
          break;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b0;
    lat_cfg = 3;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin bad++;
      $display("FAIL async_reset: got count=%0d valid=%b req=%b want 0 0 0", bus.count, bus.out_valid, bus.imem_req); end
    total++; if (bus.imem_addr !== 16'h0000) begin bad++; $display("FAIL async_reset_pc: got %h want 0000", bus.imem_addr); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.out_ready = 1'b0;
    lat_cfg = 3;
    repeat (5) @(negedge clk);
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL redir_pre_count: got %0d want 1", bus.count); end
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0100;
    @(negedge clk);
    bus.redirect = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin bad++;
      $display("FAIL redir_flush: got valid=%b count=%0d want 0 0", bus.out_valid, bus.count); end
    bus.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (acc_q.size() < 3) begin bad++; $display("FAIL redir_next_addr: got %0d accepts want >=3", acc_q.size()); end
    else if (acc_q[2] !== 16'h0100) begin bad++; $display("FAIL redir_next_addr: got %h want 0100", acc_q[2]); end
    total++;
    if (pop_q.size() < 1) begin bad++; $display("FAIL redir_first_pop: got no pops want pc 0100"); end
    else if (pop_q[0].pc !== 16'h0100 || pop_q[0].instr !== 16'hC200) begin bad++;
      $display("FAIL redir_first_pop: got pc=%h instr=%h want 0100 C200", pop_q[0].pc, pop_q[0].instr); end
  endtask

  task automatic test_halt();
    do_reset();
    lat_cfg = 3;
    @(negedge clk);
    bus.halt = 1'b1;
    repeat (9) @(negedge clk);
    total++; if (acc_q.size() != 1 || bus.imem_req !== 1'b0) begin bad++;
      $display("FAIL halt_blocks: got accepts=%0d req=%b want 1 0", acc_q.size(), bus.imem_req); end
    total++;
    if (pop_q.size() != 1) begin bad++; $display("FAIL halt_inflight_push: got %0d pops want 1", pop_q.size()); end
    else if (pop_q[0].pc !== 16'h0000 || pop_q[0].instr !== 16'hC300) begin bad++;
      $display("FAIL halt_inflight_push: got pc=%h instr=%h want 0000 C300", pop_q[0].pc, pop_q[0].instr); end
    bus.halt = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (acc_q.size() < 2) begin bad++; $display("FAIL halt_resume: got %0d accepts want >=2", acc_q.size()); end
    else if (acc_q[1] !== 16'h0002) begin bad++; $display("FAIL halt_resume: got %h want 0002", acc_q[1]); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE;
    @(negedge clk);
    bus.redirect = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (acc_q.size() < 2) begin bad++; $display("FAIL wrap_addr: got %0d accepts want >=2", acc_q.size()); end
    else if (acc_q[0] !== 16'hFFFE || acc_q[1] !== 16'h0000) begin bad++;
      $display("FAIL wrap_addr: got %h %h want FFFE 0000", acc_q[0], acc_q[1]); end
    total++;
    if (pop_q.size() < 1) begin bad++; $display("FAIL wrap_next_pc: got no pops want pc FFFE"); end
    else if (pop_q[0].pc !== 16'hFFFE || pop_q[0].next_pc !== 16'h0000 || pop_q[0].instr !== 16'h3CFE) begin bad++;
      $display("FAIL wrap_next_pc: got pc=%h npc=%h instr=%h want FFFE 0000 3CFE",
               pop_q[0].pc, pop_q[0].next_pc, pop_q[0].instr); end
  endtask

`ifdef FETCH_HALT_DETECT_EN
  task automatic test_halt_detect();
    do_reset();
    halt_trap_en = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (acc_q.size() != 4) begin bad++; $display("FAIL hd_stop: got %0d accepts want 4", acc_q.size()); end
    else if (acc_q[3] !== 16'h0006) begin bad++; $display("FAIL hd_stop: got last %h want 0006", acc_q[3]); end
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0020;
    @(negedge clk);
    bus.redirect = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (acc_q.size() < 5) begin bad++; $display("FAIL hd_restart: got %0d accepts want >=5", acc_q.size()); end
    else if (acc_q[4] !== 16'h0020) begin bad++; $display("FAIL hd_restart: got %h want 0020", acc_q[4]); end
  endtask
`endif

  initial begin
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0;
    bus.imem_ready = 1'b1; bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_redirect();
    test_halt();
    test_wrap();
`ifdef FETCH_HALT_DETECT_EN
    test_halt_detect();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised successor to the single-entry fetch stage. Generates the PC, issues requests to an instruction memory through a request/response handshake that may have variable latency, and buffers fetched {pc, next_pc, instr} entries in a DEPTH-entry queue. Decode pops entries with a valid/ready handshake. Branch redirect flushes the queue and discards the stale in-flight response; halt freezes fetch.

Parameters:
DATA_W, 16, instruction width in bits
ADDR_W, 16, PC width in bits
DEPTH, 4, queue entries; power of 2 and at least 2
RESET_PC, 0, PC value after reset
NOP_INSTR, 16'h0800, value driven on out_instr whenever out_valid=0

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
redirect  in  1  branch taken; flush queue and refetch
redirect_pc  in  ADDR_W  branch target
halt  in  1  stop issuing new requests while high
imem_req  out  1  request valid
imem_addr  out  ADDR_W  request address
imem_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  response valid
imem_rsp_data  in  DATA_W  fetched instruction
out_valid  out  1  queue head valid
out_ready  in  1  decode consumes head (stall = ~out_ready)
out_instr  out  DATA_W  head instruction, or NOP_INSTR when empty
out_pc  out  ADDR_W  head PC
out_next_pc  out  ADDR_W  head PC + DATA_W/8
count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: PC=RESET_PC; queue empty; count=0; out_valid=0; out_instr=NOP_INSTR; imem_req=0; no request outstanding; epoch=0.
- Issue rule: imem_req=1 when all of the following hold: ~halt, ~redirect, no request outstanding, and count + pending < DEPTH. This keeps a credit slot for every accepted request.
- Accept: on imem_req & imem_ready, set the outstanding flag, tag the request with the current epoch, and advance PC by DATA_W/8. PC wraps modulo 2^ADDR_W.
- Response: on imem_rsp_valid with tag == epoch, push {addr, addr+DATA_W/8, data} into the queue and clear outstanding. A stale tag clears outstanding and pushes nothing.
- Minimum latency: accept in cycle N, response no earlier than N+1, push visible at out_* in N+2. This gives back-to-back throughput of one instruction per 2 cycles (only one request outstanding).
- Pop: when out_valid & out_ready, advance the head on the next edge. Push and pop in the same cycle leave count unchanged. A push is only legal when a credit exists, so overflow is impossible. A pop on empty is ignored.
- Redirect (highest priority): at the edge, queue cleared, count=0, PC=redirect_pc, epoch toggles, and any outstanding request is marked stale. The stale response is still awaited before the next issue. A push or pop in the same cycle is discarded. Redirect on the same cycle as a stale response: the queue is still flushed and outstanding is cleared.
- Halt: blocks only new issues. An in-flight response is still pushed, and the queue keeps draining. When halt deasserts, fetch resumes from the held PC.
- Reset mid-request: all state is cleared asynchronously. A response arriving after reset with tag != 0 is dropped. Tag 0 can alias, so the memory model must also be reset by rst.
- Outputs are registered from queue state, with no combinational path from out_ready to out_*.

Optional Feature:
FETCH_HALT_DETECT_EN
- Defined: a pushed instruction equal to 16'h0000 (HALT) sets a sticky halt_seen that blocks further issue, exactly like halt. halt_seen is cleared by redirect or rst.
- Undefined: no opcode decode; only the halt port stops fetch.

Decomposition:
- Shared package fetch_pkg holds: NOP_INSTR and HALT_INSTR constants, the fetch_entry_t struct {pc, next_pc, instr}, and the instruction-size constant.
- One sub-module, fetch_fifo: DEPTH-entry circular buffer with push, pop, flush, count, and head. Pointers use an extra wrap bit for full/empty.
- The top level holds the PC, outstanding/epoch logic, and issue control.

Test Plan:
- Reset, memory latency 1, out_ready=1 -> requests at 0x0000, 0x0002, 0x0004; out_pc sequence 0x0000, 0x0002, 0x0004 with out_next_pc = pc+2; out_instr=0x0800 until the first push.
- out_ready=0 for 20 cycles -> count saturates at 4; imem_req=0 after the 4th accept; releasing out_ready drains entries in order with no loss or duplication.
- Redirect to 0x0100 while a response is outstanding -> stale data not pushed; next accepted imem_addr=0x0100; out_valid=0 for the cycle after redirect.
- halt=1 while one request is in flight -> that response is pushed, no new imem_req; halt=0 -> resumes at the next sequential PC.
- PC=0xFFFE (ADDR_W=16) -> next request address is 0x0000; out_next_pc of the 0xFFFE entry = 0x0000.
- FETCH_HALT_DETECT_EN defined, memory returns 0x0000 at 0x0006 -> no requests after 0x0006; redirect to 0x0020 restarts fetch.
